// File: rtl/alu_issue_stage.sv
// Decode/issue register ahead of the ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC, forwards operands, holds a valid/ready slot.
// Define ALU_ISSUE_PERF_EN to add the saturating perf_issued/perf_stall counters.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              fwd_ex_valid,
    input  logic [4:0]        fwd_ex_rd,
    input  logic [XLEN-1:0]   fwd_ex_data,
    input  logic              fwd_ex_load,
    input  logic              fwd_wb_valid,
    input  logic [4:0]        fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] alu_func,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_pc,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall,
`endif
    output logic              out_illegal
);

    localparam logic [FUNC_W-1:0] F_ZERO = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_SLL  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_SRL  = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_SRA  = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] F_SLTU = FUNC_W'(10);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;

    // EX wins over WB; a load in EX has no data yet, so it never forwards.
    always_comb begin
        src1 = rs1_data;
        if (rs1 == 5'd0)
            src1 = '0;
        else if (fwd_ex_valid && !fwd_ex_load && fwd_ex_rd == rs1)
            src1 = fwd_ex_data;
        else if (fwd_wb_valid && fwd_wb_rd == rs1)
            src1 = fwd_wb_data;
    end

    always_comb begin
        src2 = rs2_data;
        if (rs2 == 5'd0)
            src2 = '0;
        else if (fwd_ex_valid && !fwd_ex_load && fwd_ex_rd == rs2)
            src2 = fwd_ex_data;
        else if (fwd_wb_valid && fwd_wb_rd == rs2)
            src2 = fwd_wb_data;
    end

    logic [FUNC_W-1:0] dec_func;
    logic [XLEN-1:0]   dec_op1;
    logic [XLEN-1:0]   dec_op2;
    logic              dec_legal;
    logic              uses_rs1;
    logic              uses_rs2;

    always_comb begin
        dec_func  = F_ZERO;
        dec_op1   = '0;
        dec_op2   = '0;
        dec_legal = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_op1   = src1;
                dec_op2   = src2;
                dec_legal = (funct7 == 7'h00);
                case (funct3)
                    3'b000: begin
                        dec_func  = (funct7 == 7'h20) ? F_SUB : F_ADD;
                        dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                    3'b001: dec_func = F_SLL;
                    3'b010: dec_func = F_SLT;
                    3'b011: dec_func = F_SLTU;
                    3'b100: dec_func = F_XOR;
                    3'b101: begin
                        dec_func  = (funct7 == 7'h20) ? F_SRA : F_SRL;
                        dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                    3'b110: dec_func = F_OR;
                    default: dec_func = F_AND;
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1  = 1'b1;
                dec_op1   = src1;
                dec_op2   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_func = F_ADD;
                    3'b001: begin
                        dec_func  = F_SLL;
                        dec_op2   = XLEN'(rs2);
                        dec_legal = (funct7 == 7'h00);
                    end
                    3'b010: dec_func = F_SLT;
                    3'b011: dec_func = F_SLTU;
                    3'b100: dec_func = F_XOR;
                    3'b101: begin
                        dec_func  = (funct7 == 7'h20) ? F_SRA : F_SRL;
                        dec_op2   = XLEN'(rs2);
                        dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                    3'b110: dec_func = F_OR;
                    default: dec_func = F_AND;
                endcase
            end
            OPC_LUI: begin
                dec_func  = F_ADD;
                dec_op2   = {in_instr[31:12], 12'b0};
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec_func  = F_ADD;
                dec_op1   = in_pc;
                dec_op2   = {in_instr[31:12], 12'b0};
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_func = F_ZERO;
            dec_op1  = '0;
            dec_op2  = '0;
        end
    end

    logic stall;
    logic accept;

    assign stall = fwd_ex_load && fwd_ex_valid && (fwd_ex_rd != 5'd0) &&
                   ((uses_rs1 && fwd_ex_rd == rs1) || (uses_rs2 && fwd_ex_rd == rs2));
    assign in_ready = !flush && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            alu_func    <= F_ZERO;
            alu_op1     <= '0;
            alu_op2     <= '0;
            out_rd      <= 5'd0;
            out_wen     <= 1'b0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            alu_func    <= dec_func;
            alu_op1     <= dec_op1;
            alu_op2     <= dec_op2;
            out_rd      <= rd;
            out_wen     <= dec_legal && (rd != 5'd0);
            out_pc      <= in_pc;
            out_illegal <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (!flush) begin
            if (accept && perf_issued != 32'hFFFF_FFFF)
                perf_issued <= perf_issued + 32'd1;
            if (in_valid && stall && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue register sitting directly upstream of the ALU.
- Accepts one fetched RV32I instruction plus register-file read data and decodes ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) into the ALU func code.
- Selects and forwards operands, then holds the result in a valid/ready output register that drives the ALU's func/op1/op2 inputs.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- FUNC_W, 4, ALU func code width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  instruction present
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
rs1_data  in  XLEN  regfile read for instr[19:15]
rs2_data  in  XLEN  regfile read for instr[24:20]
fwd_ex_valid  in  1  EX result valid for forwarding
fwd_ex_rd  in  5  EX destination register
fwd_ex_data  in  XLEN  EX result
fwd_ex_load  in  1  EX holds a load; data not yet available
fwd_wb_valid  in  1  WB result valid
fwd_wb_rd  in  5  WB destination register
fwd_wb_data  in  XLEN  WB result
flush  in  1  discard held and incoming instruction
out_valid  out  1  issue register holds an instruction
out_ready  in  1  ALU/EX consumes
alu_func  out  FUNC_W  ZERO=0 ADD=1 SUB=2 SLL=3 SLT=4 XOR=5 OR=6 AND=7 SRL=8 SRA=9 SLTU=10
alu_op1  out  XLEN  operand 1
alu_op2  out  XLEN  operand 2
out_rd  out  5  destination register
out_wen  out  1  writeback enable
out_pc  out  XLEN  pc of held instruction
out_illegal  out  1  held instruction is not ALU-class or is malformed

Behaviour:
- Reset (rst=0 at clk edge): out_valid=0, alu_func=ZERO, alu_op1=alu_op2=out_pc=0, out_rd=0, out_wen=0, out_illegal=0. Reset has priority over flush and accept, including mid-transfer.
- in_ready = !stall && (!out_valid || out_ready). The input is accepted when in_valid && in_ready. Latency is 1 cycle from accept to out_valid.
- Output register: it is loaded on accept. Otherwise it holds while out_valid && !out_ready; it clears (out_valid=0) when consumed with no new accept. Back-to-back accept and consume keeps out_valid=1 with the new contents.
- Output stability: all outputs are stable while out_valid && !out_ready.
- flush=1: out_valid becomes 0 next cycle. Nothing is accepted that cycle, and in_ready is forced to 0.
- Stall: stall = fwd_ex_load && fwd_ex_valid && fwd_ex_rd!=0 && fwd_ex_rd equals a source register actually used (rs1 for OP/OP-IMM; rs2 for OP only). LUI/AUIPC never stall.
- Forwarding per source, in priority order:
  - reg==0 gives 0.
  - EX match (fwd_ex_valid, !fwd_ex_load) gives fwd_ex_data.
  - WB match gives fwd_wb_data.
  - Otherwise regfile data.
- Decode of OP (0110011): funct3 maps 000→ADD/SUB (funct7 0x00/0x20), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (0x00/0x20), 110 OR, 111 AND. Any other funct7 is illegal. op1=rs1, op2=rs2.
- Decode of OP-IMM (0010011): funct3 map as for OP, except 000 is always ADD.
  - Non-shift: op2 = sign-extended imm[11:0].
  - SLLI requires imm[11:5]=0; SRLI/SRAI require 0x00/0x20. Otherwise illegal.
  - Shift: op2 = zero-extended shamt instr[24:20].
- Decode of LUI (0110111): ADD, op1=0, op2={instr[31:12],12'b0}.
- Decode of AUIPC (0010111): ADD, op1=in_pc, op2={instr[31:12],12'b0}.
- Illegal instruction: alu_func=ZERO, op1=op2=0, out_wen=0, out_illegal=1. It still passes through the handshake.
- Writeback enable: out_wen = legal && rd!=0.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- With the macro defined: adds output ports perf_issued[31:0] (count of accepted instructions) and perf_stall[31:0] (count of cycles with in_valid && stall). Both saturate at 0xFFFFFFFF, reset to 0, and do not increment while flush=1.
- Without the macro: these ports and counters do not exist.

Test Plan:
- Reset, then in_instr=0x40208033 (sub x0,x1,x2) with rs1=5, rs2=3 → next cycle out_valid=1, alu_func=2, op1=5, op2=3, out_wen=0.
- Forwarding: addi x3,x1,-1 (0xFFF08193) with rs1_data=7, fwd_ex_rd=1, fwd_ex_data=0x10, fwd_wb_rd=1, fwd_wb_data=0x20 → op1=0x10, op2=0xFFFFFFFF, func=1, out_rd=3.
- Load-use: fwd_ex_load=1, fwd_ex_rd=1, instr srai x4,x1,3 (0x4030D213) → in_ready=0 until fwd_ex_load drops; then func=9, op2=3.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → outputs unchanged and in_ready=0; out_ready=1 → next instruction loads in the same cycle.
- Illegal: slli with imm[11:5]=0x20 (0x40009093) → out_illegal=1, func=0, out_wen=0. auipc x5,1 at pc=0x100 → op1=0x100, op2=0x1000.
- flush while out_valid=1 and in_valid=1 → next cycle out_valid=0 and the instruction is not accepted. rst=0 mid-hold → all outputs return to reset values.
